// File: rtl/tl_sram_responder_if.sv
// TileLink-UH A/D channel bundle between a client (master) and the
// tl_sram_responder manager (slave).
//
// Handshake: a beat transfers on a rising clock edge where both valid and
// ready are 1. The sender keeps valid high, and every bits field stable,
// until that edge. The sender never waits for ready before raising valid.
interface tl_sram_responder_if;
    logic        auto_in_a_valid;
    logic [2:0]  auto_in_a_bits_opcode;
    logic [2:0]  auto_in_a_bits_param;
    logic [2:0]  auto_in_a_bits_size;
    logic [6:0]  auto_in_a_bits_source;
    logic [31:0] auto_in_a_bits_address;
    logic [7:0]  auto_in_a_bits_mask;
    logic [63:0] auto_in_a_bits_data;
    logic        auto_in_a_bits_corrupt;
    logic        auto_in_a_ready;
    logic        auto_in_d_valid;
    logic [2:0]  auto_in_d_bits_opcode;
    logic [1:0]  auto_in_d_bits_param;
    logic [2:0]  auto_in_d_bits_size;
    logic [6:0]  auto_in_d_bits_source;
    logic [2:0]  auto_in_d_bits_sink;
    logic        auto_in_d_bits_denied;
    logic [63:0] auto_in_d_bits_data;
    logic        auto_in_d_bits_corrupt;
    logic        auto_in_d_ready;

    modport master (
        output auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_param,
               auto_in_a_bits_size, auto_in_a_bits_source, auto_in_a_bits_address,
               auto_in_a_bits_mask, auto_in_a_bits_data, auto_in_a_bits_corrupt,
               auto_in_d_ready,
        input  auto_in_a_ready, auto_in_d_valid, auto_in_d_bits_opcode,
               auto_in_d_bits_param, auto_in_d_bits_size, auto_in_d_bits_source,
               auto_in_d_bits_sink, auto_in_d_bits_denied, auto_in_d_bits_data,
               auto_in_d_bits_corrupt
    );

    modport slave (
        input  auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_param,
               auto_in_a_bits_size, auto_in_a_bits_source, auto_in_a_bits_address,
               auto_in_a_bits_mask, auto_in_a_bits_data, auto_in_a_bits_corrupt,
               auto_in_d_ready,
        output auto_in_a_ready, auto_in_d_valid, auto_in_d_bits_opcode,
               auto_in_d_bits_param, auto_in_d_bits_size, auto_in_d_bits_source,
               auto_in_d_bits_sink, auto_in_d_bits_denied, auto_in_d_bits_data,
               auto_in_d_bits_corrupt
    );
endinterface

// File: rtl/tl_sram_responder.sv
// TileLink-UH manager endpoint backed by a DEPTH x 64-bit register file.
// One transaction at a time, bursts up to 64 bytes (8 beats).
// Optional build macro TL_SRAM_RESPONDER_RANGE_CHECK_EN: deny requests that
// fall outside, or burst across the top of, [BASE, BASE + 8*DEPTH).
module tl_sram_responder #(
    parameter int          DEPTH   = 512,
    parameter logic [31:0] BASE    = 32'h0800_0000,
    parameter logic [2:0]  SINK_ID = 3'd0
) (
    input  logic                 clock,
    input  logic                 reset,
    tl_sram_responder_if.slave   tl,
    output logic [1:0]           dbg_state
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, PUT = 2'd1, GET = 2'd2, ACK = 2'd3} state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [2:0]      op_q, size_q, last_q;
    logic [6:0]      source_q;
    logic [AW-1:0]   index_q;
    logic            denied_q;
    logic            latch;

    logic [63:0]     mem [DEPTH];
    logic            we;
    logic [AW-1:0]   waddr;
    logic [AW-1:0]   raddr;

    // Index of the final beat: 2^(size-3)-1 for sizes 3..6, 0 below; sizes above 6 act as 6.
    function automatic logic [2:0] last_beat(input logic [2:0] size);
        logic [2:0] s;
        s = (size > 3'd6) ? 3'd6 : size;
        if (s < 3'd3) return 3'd0;
        return 3'((4'd1 << (s - 3'd3)) - 4'd1);
    endfunction

    logic        a_fire, d_fire;
    logic [31:0] req_off;
    logic [AW-1:0] req_index;
    logic [2:0]  req_last;
    logic        req_unsupported, range_bad, req_denied;
    logic [33:0] req_end_word;
    logic        unused_bits;

    assign a_fire          = tl.auto_in_a_valid && tl.auto_in_a_ready;
    assign d_fire          = tl.auto_in_d_valid && tl.auto_in_d_ready;
    assign req_off         = tl.auto_in_a_bits_address - BASE;
    assign req_index       = req_off[AW+2:3];
    assign req_last        = last_beat(tl.auto_in_a_bits_size);
    assign req_unsupported = !(tl.auto_in_a_bits_opcode inside {3'd0, 3'd1, 3'd4, 3'd5});
    // One past the last word the burst touches, relative to word 0.
    assign req_end_word    = 34'(req_off[31:3]) + 34'(req_last) + 34'd1;
`ifdef TL_SRAM_RESPONDER_RANGE_CHECK_EN
    assign range_bad = (tl.auto_in_a_bits_address < BASE) || (req_end_word > 34'(DEPTH));
`else
    assign range_bad = 1'b0;
`endif
    assign req_denied  = req_unsupported || range_bad;
    assign unused_bits = ^{tl.auto_in_a_bits_param, req_off, req_end_word};

    assign tl.auto_in_a_ready = (state_q == IDLE) || (state_q == PUT);
    assign tl.auto_in_d_valid = (state_q == GET) || (state_q == ACK);
    assign raddr     = index_q + AW'(cnt_q);
    assign dbg_state = state_q;

    // Next state, beat counter and write-port control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        we      = 1'b0;
        waddr   = index_q + AW'(cnt_q);
        case (state_q)
            IDLE: begin
                if (a_fire) begin
                    latch = 1'b1;
                    cnt_d = 3'd0;
                    if (!tl.auto_in_a_bits_opcode[2]) begin
                        // Data-carrying opcode: this fire is beat 0. Arithmetic and
                        // Logical are latched as denied, so their beats never write.
                        we    = !req_denied && !tl.auto_in_a_bits_corrupt;
                        waddr = req_index;
                        if (req_last == 3'd0) begin
                            state_d = ACK;
                        end else begin
                            // cnt holds the index of the next beat to arrive.
                            state_d = PUT;
                            cnt_d   = 3'd1;
                        end
                    end else if (tl.auto_in_a_bits_opcode == 3'd4) begin
                        state_d = GET;
                    end else begin
                        state_d = ACK;
                    end
                end
            end
            PUT: begin
                if (a_fire) begin
                    we    = !denied_q && !tl.auto_in_a_bits_corrupt;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == last_q) begin
                        state_d = ACK;
                        cnt_d   = 3'd0;
                    end
                end
            end
            GET: begin
                if (d_fire) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == last_q) begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                    end
                end
            end
            ACK: begin
                if (d_fire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // D-channel fields; all zero whenever no beat is offered.
    always_comb begin
        tl.auto_in_d_bits_opcode  = 3'd0;
        tl.auto_in_d_bits_param   = 2'd0;
        tl.auto_in_d_bits_size    = 3'd0;
        tl.auto_in_d_bits_source  = 7'd0;
        tl.auto_in_d_bits_sink    = 3'd0;
        tl.auto_in_d_bits_denied  = 1'b0;
        tl.auto_in_d_bits_data    = 64'd0;
        tl.auto_in_d_bits_corrupt = 1'b0;
        if (state_q == GET) begin
            tl.auto_in_d_bits_opcode  = 3'd1;
            tl.auto_in_d_bits_size    = size_q;
            tl.auto_in_d_bits_source  = source_q;
            tl.auto_in_d_bits_sink    = SINK_ID;
            tl.auto_in_d_bits_denied  = denied_q;
            tl.auto_in_d_bits_data    = denied_q ? 64'd0 : mem[raddr];
            tl.auto_in_d_bits_corrupt = denied_q;
        end else if (state_q == ACK) begin
            tl.auto_in_d_bits_opcode  = (op_q == 3'd5) ? 3'd2 : 3'd0;
            tl.auto_in_d_bits_size    = size_q;
            tl.auto_in_d_bits_source  = source_q;
            tl.auto_in_d_bits_sink    = SINK_ID;
            tl.auto_in_d_bits_denied  = denied_q;
        end
    end

    // State, counter and request context registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            op_q     <= 3'd0;
            size_q   <= 3'd0;
            last_q   <= 3'd0;
            source_q <= 7'd0;
            index_q  <= '0;
            denied_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                op_q     <= tl.auto_in_a_bits_opcode;
                size_q   <= tl.auto_in_a_bits_size;
                last_q   <= req_last;
                source_q <= tl.auto_in_a_bits_source;
                index_q  <= req_index;
                denied_q <= req_denied;
            end
        end
    end

    // Byte-masked memory write; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (tl.auto_in_a_bits_mask[b]) mem[waddr][b*8 +: 8] <= tl.auto_in_a_bits_data[b*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_tl_sram_responder.sv
// Scoreboard bench for tl_sram_responder: drivers push expected D beats
// into exp_q, an independent negedge monitor pops and compares them.
module tb_tl_sram_responder;
    localparam int          DEPTH = 512;
    localparam logic [31:0] BASE  = 32'h0800_0000;
    localparam int          W     = 84;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] dbg_state;

    tl_sram_responder_if tl();

    tl_sram_responder #(.DEPTH(DEPTH), .BASE(BASE), .SINK_ID(3'd0)) dut (
        .clock(clock), .reset(reset), .tl(tl), .dbg_state(dbg_state)
    );

    // Clock and watchdog
    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int           n_tests = 0;
    int           n_fail  = 0;
    int           d_fires = 0;
    logic [W-1:0] exp_q[$];
    bit           stall_mode = 1'b0;
    int           stall_k = 0;
    bit           prev_stall = 1'b0;
    logic [W-1:0] snap;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk_d(input logic [2:0] op, input logic [2:0] size,
                                         input logic [6:0] src, input logic den,
                                         input logic cor, input logic [63:0] data);
        return {2'd0, 3'd0, op, size, src, den, cor, data};
    endfunction

    function automatic logic [W-1:0] pack_d();
        return {tl.auto_in_d_bits_param, tl.auto_in_d_bits_sink, tl.auto_in_d_bits_opcode,
                tl.auto_in_d_bits_size, tl.auto_in_d_bits_source, tl.auto_in_d_bits_denied,
                tl.auto_in_d_bits_corrupt, tl.auto_in_d_bits_data};
    endfunction

    // D ready: always 1, or a 1,0,0 repeating pattern in stall mode
    always @(posedge clock) begin
        #1;
        if (stall_mode) begin
            tl.auto_in_d_ready = (stall_k % 3 == 0);
            stall_k++;
        end else begin
            tl.auto_in_d_ready = 1'b1;
        end
    end

    // Monitor: compare every D fire against the head of exp_q
    always @(negedge clock) begin
        if (reset) begin
            if (prev_stall) check("d_hold", {1'b0, tl.auto_in_d_valid, pack_d()}, {1'b0, 1'b1, snap});
            if (tl.auto_in_d_valid) check("ready_valid_excl", 128'(tl.auto_in_a_ready), 128'd0);
            if (tl.auto_in_d_valid && tl.auto_in_d_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_d: got %h expected none", pack_d());
                end else begin
                    check("d_beat", 128'(pack_d()), 128'(exp_q.pop_front()));
                end
                d_fires++;
            end
            prev_stall = tl.auto_in_d_valid && !tl.auto_in_d_ready;
            snap       = pack_d();
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Driver tasks
    task automatic a_beat(input logic [2:0] op, input logic [2:0] size, input logic [6:0] src,
                          input logic [31:0] addr, input logic [7:0] mask, input logic [63:0] data);
        int n = 0;
        tl.auto_in_a_bits_opcode  = op;
        tl.auto_in_a_bits_param   = 3'd0;
        tl.auto_in_a_bits_size    = size;
        tl.auto_in_a_bits_source  = src;
        tl.auto_in_a_bits_address = addr;
        tl.auto_in_a_bits_mask    = mask;
        tl.auto_in_a_bits_data    = data;
        tl.auto_in_a_bits_corrupt = 1'b0;
        tl.auto_in_a_valid        = 1'b1;
        while (!tl.auto_in_a_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL a_timeout: got no a_ready expected a_ready within 200 cycles");
        end
        @(posedge clock);
        #1;
        tl.auto_in_a_valid = 1'b0;
    endtask

    task automatic put_burst(input logic [2:0] op, input logic [2:0] size, input logic [6:0] src,
                             input logic [31:0] addr, input logic [63:0] data0,
                             input logic [7:0] mask, input int beats);
        for (int i = 0; i < beats; i++) a_beat(op, size, src, addr, mask, data0 + 64'(i));
    endtask

    task automatic do_get(input logic [2:0] size, input logic [6:0] src, input logic [31:0] addr);
        a_beat(3'd4, size, src, addr, 8'hFF, 64'd0);
        @(negedge clock);
        check("get_latency", 128'(tl.auto_in_d_valid), 128'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (n >= 300) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        int start;
        int n;
        tl.auto_in_a_valid        = 1'b0;
        tl.auto_in_a_bits_opcode  = 3'd0;
        tl.auto_in_a_bits_param   = 3'd0;
        tl.auto_in_a_bits_size    = 3'd0;
        tl.auto_in_a_bits_source  = 7'd0;
        tl.auto_in_a_bits_address = 32'd0;
        tl.auto_in_a_bits_mask    = 8'd0;
        tl.auto_in_a_bits_data    = 64'd0;
        tl.auto_in_a_bits_corrupt = 1'b0;

        // Reset state
        #2;
        check("rst_a_ready", 128'(tl.auto_in_a_ready), 128'd1);
        check("rst_d_valid", 128'(tl.auto_in_d_valid), 128'd0);
        check("rst_d_fields", 128'(pack_d()), 128'd0);
        check("rst_state", 128'(dbg_state), 128'd0);
        #10;
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Single-beat PutFull then Get
        exp_q.push_back(mk_d(3'd0, 3'd3, 7'd5, 1'b0, 1'b0, 64'd0));
        put_burst(3'd0, 3'd3, 7'd5, BASE + 32'h10, 64'h1122334455667788, 8'hFF, 1);
        drain();
        exp_q.push_back(mk_d(3'd1, 3'd3, 7'd6, 1'b0, 1'b0, 64'h1122334455667788));
        do_get(3'd3, 7'd6, BASE + 32'h10);
        drain();

        // 64-byte burst write then read back
        exp_q.push_back(mk_d(3'd0, 3'd6, 7'h12, 1'b0, 1'b0, 64'd0));
        put_burst(3'd0, 3'd6, 7'h12, BASE, 64'd0, 8'hFF, 8);
        drain();
        for (int i = 0; i < 8; i++) exp_q.push_back(mk_d(3'd1, 3'd6, 7'h13, 1'b0, 1'b0, 64'(i)));
        do_get(3'd6, 7'h13, BASE);
        drain();
        check("a_ready_after_get", 128'(tl.auto_in_a_ready), 128'd1);

        // PutPartial low four bytes onto a zero word
        exp_q.push_back(mk_d(3'd0, 3'd3, 7'd1, 1'b0, 1'b0, 64'd0));
        put_burst(3'd0, 3'd3, 7'd1, BASE + 32'h100, 64'd0, 8'hFF, 1);
        drain();
        exp_q.push_back(mk_d(3'd0, 3'd3, 7'd2, 1'b0, 1'b0, 64'd0));
        put_burst(3'd1, 3'd3, 7'd2, BASE + 32'h100, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1);
        drain();
        exp_q.push_back(mk_d(3'd1, 3'd3, 7'd3, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF));
        do_get(3'd3, 7'd3, BASE + 32'h100);
        drain();

        // Burst Get under D back-pressure
        stall_mode = 1'b1;
        stall_k    = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back(mk_d(3'd1, 3'd6, 7'h21, 1'b0, 1'b0, 64'(i)));
        start = d_fires;
        do_get(3'd6, 7'h21, BASE);
        drain();
        stall_mode = 1'b0;
        check("stall_beat_count", 128'(d_fires - start), 128'd8);
        check("a_ready_after_stall", 128'(tl.auto_in_a_ready), 128'd1);

        // Arithmetic opcode: beats consumed, no write, denied ack
        exp_q.push_back(mk_d(3'd0, 3'd4, 7'h30, 1'b0, 1'b0, 64'd0));
        put_burst(3'd0, 3'd4, 7'h30, BASE + 32'h200, 64'hA0, 8'hFF, 2);
        drain();
        exp_q.push_back(mk_d(3'd0, 3'd4, 7'h31, 1'b1, 1'b0, 64'd0));
        put_burst(3'd2, 3'd4, 7'h31, BASE + 32'h200, 64'hFFFF_FFFF_FFFF_FFF0, 8'hFF, 2);
        drain();
        exp_q.push_back(mk_d(3'd1, 3'd4, 7'h32, 1'b0, 1'b0, 64'hA0));
        exp_q.push_back(mk_d(3'd1, 3'd4, 7'h32, 1'b0, 1'b0, 64'hA1));
        do_get(3'd4, 7'h32, BASE + 32'h200);
        drain();

        // Hint and an unsupported data-less opcode
        exp_q.push_back(mk_d(3'd2, 3'd3, 7'h40, 1'b0, 1'b0, 64'd0));
        a_beat(3'd5, 3'd3, 7'h40, BASE, 8'h00, 64'd0);
        drain();
        exp_q.push_back(mk_d(3'd0, 3'd3, 7'h41, 1'b1, 1'b0, 64'd0));
        a_beat(3'd6, 3'd3, 7'h41, BASE, 8'h00, 64'd0);
        drain();

        // Get one word past the top of the range
        exp_q.push_back(mk_d(3'd0, 3'd3, 7'h50, 1'b0, 1'b0, 64'd0));
        put_burst(3'd0, 3'd3, 7'h50, BASE, 64'hCAFE_F00D_1234_5678, 8'hFF, 1);
        drain();
`ifdef TL_SRAM_RESPONDER_RANGE_CHECK_EN
        exp_q.push_back(mk_d(3'd1, 3'd3, 7'h51, 1'b1, 1'b1, 64'd0));
`else
        exp_q.push_back(mk_d(3'd1, 3'd3, 7'h51, 1'b0, 1'b0, 64'hCAFE_F00D_1234_5678));
`endif
        do_get(3'd3, 7'h51, BASE + 32'(8 * DEPTH));
        drain();

        // Reset during beat 3 of a burst Get
        exp_q.push_back(mk_d(3'd1, 3'd6, 7'h60, 1'b0, 1'b0, 64'hCAFE_F00D_1234_5678));
        for (int i = 1; i < 8; i++) exp_q.push_back(mk_d(3'd1, 3'd6, 7'h60, 1'b0, 1'b0, 64'(i)));
        start = d_fires;
        do_get(3'd6, 7'h60, BASE);
        n = 0;
        while (d_fires < start + 3 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("burst_before_reset", 128'(d_fires - start), 128'd3);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_d_valid", 128'(tl.auto_in_d_valid), 128'd0);
        check("rst_async_a_ready", 128'(tl.auto_in_a_ready), 128'd1);
        check("rst_async_state", 128'(dbg_state), 128'd0);
        exp_q.delete();
        @(negedge clock);
        #2;
        reset = 1'b1;
        @(posedge clock);
        #1;
        exp_q.push_back(mk_d(3'd1, 3'd3, 7'h61, 1'b0, 1'b0, 64'd2));
        do_get(3'd3, 7'h61, BASE + 32'h10);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
